tdm_demux: RTL and testbench
============================

// Module: tdm_demux
// PURPOSE
//  Receive end of the team's time-division link: the transmit side muxes NCH channels onto one
//  serial word lane, one channel per beat, and marks channel 0 with fsync.
//  This block tracks the slot position, locks onto fsync and steers each beat into a per-channel
//  holding register, pulsing a one-hot update strobe. Sits between the link input and the
//  per-channel consumers.
// PARAMETERS
//  NCH   4  number of channels/slots per frame (>=2)
//  W     1  bits per slot word
//  LOSS  2  consecutive missing fsync at slot 0 before lock is dropped (>=1)
// PORTS
//  clk         in   1      single clock, rising edge
//  rst_n       in   1      reset, asynchronous, active-low
//  din         in   W      slot word for current beat
//  valid       in   1      din/fsync meaningful this cycle (one beat)
//  fsync       in   1      beat is slot 0 (qualified by valid)
//  dout        out  NCH*W  channel registers; ch k at [k*W +: W]
//  upd         out  NCH    one-hot: channel k written on the last edge
//  frame_done  out  1      slot NCH-1 written on the last edge
//  locked      out  1      1 while in LOCK
//  err         out  1      1-cycle pulse: sync violation on the last beat
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=HUNT, slot=0, miss=0, dout=0, upd=0, frame_done=0,
//    locked=0, err=0. Takes effect immediately, including mid-frame. Resumes HUNT on release.
//  - All outputs are registered. A beat sampled at edge E updates dout and drives upd,
//    frame_done, err for exactly the cycle after E. Latency is 1 edge.
//  - valid=0: no state change; slot and dout hold; upd, frame_done and err are 0 next cycle.
//  - HUNT:
//    - valid&&!fsync: beat discarded, dout unchanged.
//    - valid&&fsync: write ch0, upd=1<<0, slot<=1 (mod NCH), miss<=0, go LOCK (locked=1).
//  - LOCK, per valid beat, in precedence order:
//    a) fsync && slot!=0: misalignment. Realign: write ch0, upd=1<<0, slot<=1, err=1.
//       miss unchanged.
//    b) fsync && slot==0: write ch0, slot<=1, miss<=0.
//    c) !fsync && slot==0: missing sync. err=1 and miss<=miss+1.
//       - If miss+1 < LOSS: write ch0 normally, slot<=1.
//       - If miss+1 == LOSS: beat discarded, go HUNT, locked=0, slot<=0, miss<=0.
//    d) !fsync && slot!=0: write ch[slot], upd=1<<slot, slot<=slot+1 (wraps NCH-1 -> 0).
//  - frame_done=1 whenever slot NCH-1 was written (case d with slot==NCH-1).
//  - dout channels hold their last value indefinitely. Leaving LOCK does not clear dout.
//  - upd is always one-hot or zero; err is never high for more than one cycle per beat.
//  - Slot counter width is $clog2(NCH); miss counter width is $clog2(LOSS+1); no overflow.
//    NCH not a power of 2 must still wrap at NCH-1.
// STRUCTURE
//  - Shared package tdm_pkg:
//    - state encoding localparams ST_HUNT=1'b0, ST_LOCK=1'b1;
//    - slot-width helper (clog2);
//    - the same NCH/W defaults used by the transmit side.
//  - One sub-module: tdm_slot_cnt.
//    - Mod-NCH counter with inc, load-to-1 (realign) and clear inputs; outputs slot.
//  - Top level holds: FSM, miss counter, channel register array, output strobes.
// TESTING (NCH=4, W=1, LOSS=2)
//  1. Async reset: rst_n=0 between clock edges mid-frame
//     -> dout=0000, upd=0, locked=0, err=0 without waiting for a clock edge.
//  2. HUNT discard: 3 valid beats, din=1, fsync=0 -> dout stays 0000, upd=0, locked=0.
//  3. Lock + frame: beats fsync=1/din=1, then din=0, 1, 1
//     -> upd 0001,0010,0100,1000 on successive cycles; dout=1101 (ch3..ch0);
//        frame_done high on 4th; locked=1 from 1st.
//  4. Valid gaps: same stream as 3, with valid=0 for 2 cycles between each beat
//     -> identical dout=1101; upd=0 in gap cycles; slot not advanced.
//  5. Misplaced fsync: locked, fsync=1 at slot 2 with din=1
//     -> err 1 cycle, upd=0001, ch0=1; next beat goes to ch1.
//  6. Lock loss: 2 frames with no fsync at slot 0
//     -> err on each slot-0 beat; 1st still written; after 2nd locked=0, that beat dropped,
//        further beats without fsync leave dout unchanged.

Source files
------------

// File: rtl/tdm_pkg.sv
// Shared definitions for the time-division link (transmit and receive sides).
package tdm_pkg;

  // Default frame shape shared with the transmit side
  localparam int NCH_DEF = 4;
  localparam int W_DEF   = 1;

  // Receive-side sync state: hunting for fsync, or locked onto the frame
  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } tdm_state_e;

  // Counter width needed to hold values 0..n-1
  function automatic int slot_width(input int n);
    return $clog2(n);
  endfunction

endpackage

// File: rtl/tdm_slot_cnt.sv
// Mod-NCH slot position counter with increment, realign-to-1 and clear.
module tdm_slot_cnt
  import tdm_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int SW  = slot_width(NCH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          load1,
  input  logic          clr,
  output logic [SW-1:0] slot
);

  logic [SW-1:0] slot_d, slot_q;

  // Next slot: clear wins over realign, realign wins over increment; wraps at NCH-1
  always_comb begin
    slot_d = slot_q;
    if (clr) begin
      slot_d = '0;
    end else if (load1) begin
      slot_d = SW'(1);
    end else if (inc) begin
      if (slot_q == SW'(NCH - 1)) begin
        slot_d = '0;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  // Slot register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;

endmodule

// File: rtl/tdm_demux.sv
// TDM receive demultiplexer: locks onto fsync and steers beats into channel registers.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NCH  = NCH_DEF,
  parameter int W    = W_DEF,
  parameter int LOSS = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [W-1:0]     din,
  input  logic             valid,
  input  logic             fsync,
  output logic [NCH*W-1:0] dout,
  output logic [NCH-1:0]   upd,
  output logic             frame_done,
  output logic             locked,
  output logic             err
);

  localparam int SW = slot_width(NCH);
  localparam int MW = slot_width(LOSS + 1);

  tdm_state_e       state_d, state_q;
  logic [MW-1:0]    miss_d, miss_q;
  logic [MW:0]      miss_inc;
  logic [NCH*W-1:0] dout_d, dout_q;
  logic [NCH-1:0]   upd_d, upd_q;
  logic             frame_done_d, frame_done_q;
  logic             err_d, err_q;
  logic             wr_en;
  logic [SW-1:0]    wr_ch;
  logic             cnt_inc, cnt_load1, cnt_clr;
  logic [SW-1:0]    slot;

  tdm_slot_cnt #(
    .NCH (NCH),
    .SW  (SW)
  ) u_slot_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .load1 (cnt_load1),
    .clr   (cnt_clr),
    .slot  (slot)
  );

  // Sync FSM: decides per valid beat which channel is written, slot movement and sync errors
  always_comb begin
    state_d      = state_q;
    miss_d       = miss_q;
    miss_inc     = {1'b0, miss_q} + 1'b1;
    wr_en        = 1'b0;
    wr_ch        = '0;
    frame_done_d = 1'b0;
    err_d        = 1'b0;
    cnt_inc      = 1'b0;
    cnt_load1    = 1'b0;
    cnt_clr      = 1'b0;
    if (valid) begin
      unique case (state_q)
        ST_HUNT: begin
          if (fsync) begin
            wr_en     = 1'b1;
            cnt_load1 = 1'b1;
            miss_d    = '0;
            state_d   = ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (fsync) begin
            wr_en     = 1'b1;
            cnt_load1 = 1'b1;
            if (slot != '0) begin
              err_d = 1'b1;
            end else begin
              miss_d = '0;
            end
          end else if (slot == '0) begin
            err_d = 1'b1;
            if (miss_inc < (MW + 1)'(LOSS)) begin
              wr_en     = 1'b1;
              cnt_load1 = 1'b1;
              miss_d    = miss_inc[MW-1:0];
            end else begin
              state_d = ST_HUNT;
              cnt_clr = 1'b1;
              miss_d  = '0;
            end
          end else begin
            wr_en        = 1'b1;
            wr_ch        = slot;
            cnt_inc      = 1'b1;
            frame_done_d = (slot == SW'(NCH - 1));
          end
        end
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Channel write decode: one-hot strobe and the addressed holding register
  always_comb begin
    dout_d = dout_q;
    upd_d  = '0;
    for (int k = 0; k < NCH; k++) begin
      if (wr_en && (wr_ch == SW'(k))) begin
        dout_d[k*W +: W] = din;
        upd_d[k]         = 1'b1;
      end
    end
  end

  // State, miss counter, channel registers and output strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_HUNT;
      miss_q       <= '0;
      dout_q       <= '0;
      upd_q        <= '0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_q       <= miss_d;
      dout_q       <= dout_d;
      upd_q        <= upd_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
    end
  end

  assign dout       = dout_q;
  assign upd        = upd_q;
  assign frame_done = frame_done_q;
  assign locked     = (state_q == ST_LOCK);
  assign err        = err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux (NCH=4, W=1, LOSS=2) using a scoreboard queue.
module tb_tdm_demux;

  localparam int NCH  = 4;
  localparam int W    = 1;
  localparam int LOSS = 2;

  // Expected post-edge outputs: dout, upd, frame_done, locked, err
  typedef struct packed {
    logic [3:0] dout;
    logic [3:0] upd;
    logic       fd;
    logic       lk;
    logic       err;
  } exp_t;

  logic           clk;
  logic           rst_n;
  logic [W-1:0]   din;
  logic           valid;
  logic           fsync;
  logic [NCH-1:0] dout;
  logic [NCH-1:0] upd;
  logic           frame_done;
  logic           locked;
  logic           err;
  logic [10:0]    obs;

  exp_t sbq[$];
  exp_t exp_e;
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model state
  logic [3:0] m_dout;
  int         m_slot;
  int         m_miss;
  logic       m_lock;

  tdm_demux #(
    .NCH  (NCH),
    .W    (W),
    .LOSS (LOSS)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din        (din),
    .valid      (valid),
    .fsync      (fsync),
    .dout       (dout),
    .upd        (upd),
    .frame_done (frame_done),
    .locked     (locked),
    .err        (err)
  );

  assign obs = {dout, upd, frame_done, locked, err};

  // Free-running clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  // Clear the reference model to its reset state
  task automatic modelReset();
    m_dout = '0;
    m_slot = 0;
    m_miss = 0;
    m_lock = 1'b0;
  endtask

  // Drive one cycle of input, predict the result, push it, and step past the edge
  task automatic applyStimulus(input logic v, input logic f, input logic d);
    exp_t e;
    e     = '0;
    valid = v;
    fsync = f;
    din   = d;
    if (v) begin
      if (!m_lock) begin
        if (f) begin
          m_dout[0] = d;
          e.upd     = 4'b0001;
          m_slot    = 1;
          m_miss    = 0;
          m_lock    = 1'b1;
        end
      end else if (f) begin
        if (m_slot != 0) e.err = 1'b1;
        else m_miss = 0;
        m_dout[0] = d;
        e.upd     = 4'b0001;
        m_slot    = 1;
      end else if (m_slot == 0) begin
        e.err = 1'b1;
        if (m_miss + 1 < LOSS) begin
          m_miss    = m_miss + 1;
          m_dout[0] = d;
          e.upd     = 4'b0001;
          m_slot    = 1;
        end else begin
          m_lock = 1'b0;
          m_slot = 0;
          m_miss = 0;
        end
      end else begin
        m_dout[m_slot] = d;
        e.upd          = 4'b0001 << m_slot;
        e.fd           = (m_slot == NCH - 1);
        m_slot         = (m_slot + 1) % NCH;
      end
    end
    e.dout = m_dout;
    e.lk   = m_lock;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    valid = 1'b0;
    fsync = 1'b0;
  endtask

  // Pulse reset between clock edges and resynchronise the model
  task automatic pulseReset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
  endtask

  // Async reset, including an assertion mid-frame with no clock edge
  task automatic test_reset();
    #3;
    n_checks++;
    if (obs !== 11'b0) begin
      n_err++;
      $display("[TB] FAIL reset_initial: got %b want %b", obs, 11'b0);
    end
    #9;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      exp_e = sbq.pop_front();
      n_checks++;
      if (i == 1 && obs !== exp_e) begin
        n_err++;
        $display("[TB] FAIL reset_prefill: got %b want %b", obs, exp_e);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 11'b0) begin
      n_err++;
      $display("[TB] FAIL reset_midframe: got %b want %b", obs, 11'b0);
    end
    #1;
    rst_n = 1'b1;
    modelReset();
    @(posedge clk);
    #1;
  endtask

  // Unsynchronised beats in HUNT are discarded
  task automatic test_hunt_discard();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1);
      exp_e = sbq.pop_front();
      n_checks++;
      if (obs !== exp_e) begin
        n_err++;
        $display("[TB] FAIL hunt_discard beat %0d: got %b want %b", i, obs, exp_e);
      end
    end
  endtask

  // Lock on fsync and fill one full frame
  task automatic test_lock_frame();
    logic [3:0] upd_want;
    logic [3:0] fs_tab;
    logic [3:0] d_tab;
    fs_tab = 4'b0001;
    d_tab  = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, fs_tab[i], d_tab[i]);
      exp_e = sbq.pop_front();
      n_checks++;
      if (obs !== exp_e) begin
        n_err++;
        $display("[TB] FAIL lock_frame beat %0d: got %b want %b", i, obs, exp_e);
      end
      upd_want = 4'b0001 << i;
      n_checks++;
      if (upd !== upd_want || locked !== 1'b1 || frame_done !== (i == 3)) begin
        n_err++;
        $display("[TB] FAIL lock_frame_strobe beat %0d: got upd=%b lk=%b fd=%b want upd=%b lk=1 fd=%0d",
                 i, upd, locked, frame_done, upd_want, (i == 3));
      end
    end
    n_checks++;
    if (dout !== 4'b1101) begin
      n_err++;
      $display("[TB] FAIL lock_frame_dout: got %b want %b", dout, 4'b1101);
    end
  endtask

  // Same frame with two idle cycles between beats
  task automatic test_valid_gaps();
    logic [3:0] fs_tab;
    logic [3:0] d_tab;
    fs_tab = 4'b0001;
    d_tab  = 4'b1101;
    pulseReset();
    for (int i = 0; i < 12; i++) begin
      if (i % 3 == 0) applyStimulus(1'b1, fs_tab[i/3], d_tab[i/3]);
      else applyStimulus(1'b0, 1'b1, 1'b0);
      exp_e = sbq.pop_front();
      n_checks++;
      if (obs !== exp_e) begin
        n_err++;
        $display("[TB] FAIL valid_gaps cycle %0d: got %b want %b", i, obs, exp_e);
      end
    end
    n_checks++;
    if (dout !== 4'b1101) begin
      n_err++;
      $display("[TB] FAIL valid_gaps_dout: got %b want %b", dout, 4'b1101);
    end
  endtask

  // fsync arriving at slot 2 realigns the frame and flags an error
  task automatic test_misplaced_fsync();
    logic [5:0] fs_tab;
    logic [5:0] d_tab;
    fs_tab = 6'b000101;
    d_tab  = 6'b110100;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, fs_tab[i], d_tab[i]);
      exp_e = sbq.pop_front();
      n_checks++;
      if (obs !== exp_e) begin
        n_err++;
        $display("[TB] FAIL misplaced_fsync beat %0d: got %b want %b", i, obs, exp_e);
      end
      if (i == 2) begin
        n_checks++;
        if (err !== 1'b1 || upd !== 4'b0001 || dout[0] !== 1'b1) begin
          n_err++;
          $display("[TB] FAIL misplaced_realign: got err=%b upd=%b ch0=%b want err=1 upd=0001 ch0=1",
                   err, upd, dout[0]);
        end
      end
      if (i == 3) begin
        n_checks++;
        if (err !== 1'b0 || upd !== 4'b0010) begin
          n_err++;
          $display("[TB] FAIL misplaced_next: got err=%b upd=%b want err=0 upd=0010", err, upd);
        end
      end
    end
  endtask

  // Two frames without fsync drop lock; later unsynced beats are ignored
  task automatic test_lock_loss();
    logic [3:0] held;
    for (int i = 0; i < 13; i++) begin
      applyStimulus(1'b1, 1'b0, (i % 2 == 0));
      exp_e = sbq.pop_front();
      n_checks++;
      if (obs !== exp_e) begin
        n_err++;
        $display("[TB] FAIL lock_loss beat %0d: got %b want %b", i, obs, exp_e);
      end
      if (i == 4) begin
        n_checks++;
        if (err !== 1'b1 || locked !== 1'b0 || upd !== 4'b0000) begin
          n_err++;
          $display("[TB] FAIL lock_loss_drop: got err=%b lk=%b upd=%b want err=1 lk=0 upd=0000",
                   err, locked, upd);
        end
      end
    end
    held = m_dout;
    n_checks++;
    if (dout !== held || locked !== 1'b0) begin
      n_err++;
      $display("[TB] FAIL lock_loss_hold: got dout=%b lk=%b want dout=%b lk=0", dout, locked, held);
    end
  endtask

  // Random mostly-well-formed traffic with occasional gaps and sync faults
  task automatic test_random();
    logic v;
    logic f;
    logic d;
    for (int i = 0; i < 300; i++) begin
      v = ($urandom_range(0, 3) != 0);
      if (m_slot == 0) f = ($urandom_range(0, 9) != 0);
      else f = ($urandom_range(0, 19) == 0);
      d = 1'($urandom_range(0, 1));
      applyStimulus(v, f, d);
      exp_e = sbq.pop_front();
      n_checks++;
      if (obs !== exp_e) begin
        n_err++;
        $display("[TB] FAIL random beat %0d: got %b want %b", i, obs, exp_e);
      end
    end
  endtask

  // Test sequence
  initial begin
    rst_n = 1'b0;
    valid = 1'b0;
    fsync = 1'b0;
    din   = '0;
    modelReset();
    test_reset();
    test_hunt_discard();
    test_lock_frame();
    test_valid_gaps();
    test_misplaced_fsync();
    test_lock_loss();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
